// File: rtl/arb_requester_nbit.sv
// Requester-side agent for an N-bit fixed-priority arbiter: counts pending pushes per
// client, requests service, and issues one valid/ready transaction per legal grant.
module arb_requester_nbit #(
    parameter int N     = 4,
    parameter int CNT_W = 4,
    parameter int ID_W  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_push,
    output logic [N-1:0]    o_request,
    input  logic [N-1:0]    i_grant,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id,
    input  logic            i_ready,
    output logic            o_overflow,
    output logic            o_err,
    output logic            o_pending_any
);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];
    logic [N-1:0]     nonzero;
    logic [N-1:0]     nonzero_next;
    logic [N-1:0]     pop_vec;
    logic             pop;
    logic             ovf;
    logic             any_next;
    logic             grant_onehot;
    logic             grant_legal;
    logic [ID_W-1:0]  grant_id;

    // A push and a pop on the same client cancel; a push that finds the counter
    // saturated (and is not cancelled by a pop) is dropped and flagged.
    always_comb begin
        ovf = 1'b0;
        pop = (state == ISSUE) && i_ready;
        for (int i = 0; i < N; i++) begin
            nonzero[i]  = (cnt[i] != '0);
            pop_vec[i]  = pop && (o_id == ID_W'(i));
            cnt_next[i] = cnt[i];
            if (i_push[i] && !pop_vec[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    ovf = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end else if (!i_push[i] && pop_vec[i]) begin
                cnt_next[i] = cnt[i] - CNT_W'(1);
            end
            nonzero_next[i] = (cnt_next[i] != '0);
        end
        any_next = |nonzero_next;
    end

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < N; i++) begin
            if (i_grant[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

    assign grant_onehot = (i_grant != '0) && ((i_grant & (i_grant - N'(1))) == '0);
    assign grant_legal  = grant_onehot && ((i_grant & nonzero) != '0);

    // Requests drop while a transaction is outstanding so the arbiter releases the grant.
    assign o_request     = (state == ISSUE) ? '0 : nonzero;
    assign o_pending_any = |nonzero;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_valid    <= 1'b0;
            o_id       <= '0;
            o_overflow <= 1'b0;
            o_err      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
            o_overflow <= ovf;
            o_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_grant != '0) begin
                        o_err <= 1'b1;
                    end
                    if (|nonzero) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (i_grant != '0) begin
                        if (grant_legal) begin
                            o_id    <= grant_id;
                            o_valid <= 1'b1;
                            state   <= ISSUE;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end else if (!(|nonzero)) begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= any_next ? REQ : IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_requester_nbit.sv
// Bench for arb_requester_nbit: directed scenarios plus a randomized run checked against
// per-client pending counts, with a registered highest-index-first arbiter in the loop.
module tb_arb_requester_nbit;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int ID_W  = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    push = '0;
    logic            ready = 1'b0;
    logic [N-1:0]    request;
    logic [N-1:0]    grant;
    logic [N-1:0]    arb_q = '0;
    logic [N-1:0]    force_grant = '0;
    logic            force_en = 1'b0;
    logic            valid;
    logic [ID_W-1:0] id;
    logic            overflow;
    logic            err;
    logic            pending_any;

    int vectors = 0;
    int miscompares = 0;

    arb_requester_nbit #(.N(N), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_push        (push),
        .o_request     (request),
        .i_grant       (grant),
        .o_valid       (valid),
        .o_id          (id),
        .i_ready       (ready),
        .o_overflow    (overflow),
        .o_err         (err),
        .o_pending_any (pending_any)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] top_bit(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Arbiter model: registered grant to the highest-index requester.
    always @(posedge clk) arb_q <= rst_n ? top_bit(request) : '0;
    assign grant = force_en ? force_grant : arb_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push = '1; ready = 1'b0; force_en = 1'b0;
        tick(); tick();
        vectors++; if (valid !== 1'b0 || request !== '0) begin miscompares++; $display("FAIL reset_hold valid=%b request=%b, expected 0/0000", valid, request); end
        rst_n = 1'b1; push = '0;
        vectors++; if ({valid, id, overflow, err, pending_any, request} !== '0) begin miscompares++; $display("FAIL reset_outputs got valid=%b id=%0d ovf=%b err=%b pend=%b req=%b, expected all 0", valid, id, overflow, err, pending_any, request); end
        tick();
        vectors++; if (request !== '0) begin miscompares++; $display("FAIL reset_req_after got=%b exp=0000", request); end
        vectors++; if (pending_any !== 1'b0) begin miscompares++; $display("FAIL reset_pending_after got=%b exp=0", pending_any); end
    endtask

    task automatic test_single();
        push = 4'b0010; ready = 1'b1; tick(); push = '0;
        vectors++; if (request !== 4'b0010 || valid !== 1'b0) begin miscompares++; $display("FAIL single_req req=%b valid=%b, expected 0010/0", request, valid); end
        tick();
        vectors++; if (valid !== 1'b0 || request !== 4'b0010) begin miscompares++; $display("FAIL single_wait valid=%b req=%b, expected 0/0010", valid, request); end
        tick();
        vectors++; if (valid !== 1'b1 || id !== 2'd1) begin miscompares++; $display("FAIL single_issue valid=%b id=%0d, expected 1/1", valid, id); end
        vectors++; if (request !== '0) begin miscompares++; $display("FAIL single_req_in_issue got=%b exp=0000", request); end
        tick();
        vectors++; if (valid !== 1'b0 || request !== '0 || pending_any !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL single_done valid=%b req=%b pend=%b err=%b, expected all 0", valid, request, pending_any, err); end
        tick();
        vectors++; if (valid !== 1'b0 || err !== 1'b0 || request !== '0) begin miscompares++; $display("FAIL single_idle valid=%b err=%b req=%b, expected all 0", valid, err, request); end
    endtask

    task automatic test_priority();
        push = 4'b1001; ready = 1'b1; tick(); push = '0;
        vectors++; if (request !== 4'b1001) begin miscompares++; $display("FAIL prio_req_both got=%b exp=1001", request); end
        tick(); tick();
        vectors++; if (valid !== 1'b1 || id !== 2'd3 || request !== '0) begin miscompares++; $display("FAIL prio_first valid=%b id=%0d req=%b, expected 1/3/0000", valid, id, request); end
        tick();
        vectors++; if (valid !== 1'b0 || request !== 4'b0001) begin miscompares++; $display("FAIL prio_rereq valid=%b req=%b, expected 0/0001", valid, request); end
        tick();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL prio_gap valid=%b exp=0", valid); end
        tick();
        vectors++; if (valid !== 1'b1 || id !== 2'd0) begin miscompares++; $display("FAIL prio_second valid=%b id=%0d, expected 1/0", valid, id); end
        tick();
        vectors++; if (valid !== 1'b0 || pending_any !== 1'b0) begin miscompares++; $display("FAIL prio_done valid=%b pend=%b, expected 0/0", valid, pending_any); end
    endtask

    task automatic test_backpressure();
        int  n;
        logic done;
        ready = 1'b0; push = 4'b0100; tick(); tick(); push = '0;
        tick();
        vectors++; if (valid !== 1'b1 || id !== 2'd2) begin miscompares++; $display("FAIL bp_issue valid=%b id=%0d, expected 1/2", valid, id); end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++; if (valid !== 1'b1 || id !== 2'd2 || request !== '0 || pending_any !== 1'b1) begin miscompares++; $display("FAIL bp_hold cycle %0d valid=%b id=%0d req=%b pend=%b, expected 1/2/0000/1", k, valid, id, request, pending_any); end
        end
        ready = 1'b1; tick();
        vectors++; if (valid !== 1'b0 || request !== 4'b0100 || pending_any !== 1'b1) begin miscompares++; $display("FAIL bp_one_pop valid=%b req=%b pend=%b, expected 0/0100/1", valid, request, pending_any); end
        n = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (valid && ready) n++;
            tick();
            if (!valid && !pending_any) done = 1'b1;
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_drain_timeout drained=%b exp=1", done); end
        vectors++; if (n != 1) begin miscompares++; $display("FAIL bp_drain_count got=%0d exp=1", n); end
    endtask

    task automatic test_saturation();
        int  n;
        logic done;
        ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            push = 4'b0100; tick();
            vectors++; if (overflow !== (k == 16)) begin miscompares++; $display("FAIL sat_ovf push %0d got=%b exp=%b", k, overflow, (k == 16)); end
        end
        push = '0; tick();
        vectors++; if (overflow !== 1'b0 || valid !== 1'b1 || id !== 2'd2) begin miscompares++; $display("FAIL sat_after ovf=%b valid=%b id=%0d, expected 0/1/2", overflow, valid, id); end
        push = 4'b0100; ready = 1'b1; tick(); push = '0;
        vectors++; if (overflow !== 1'b0 || pending_any !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL sat_pushpop ovf=%b pend=%b valid=%b, expected 0/1/0", overflow, pending_any, valid); end
        n = 0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (valid && ready) n++;
            tick();
            if (!valid && !pending_any) done = 1'b1;
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sat_drain_timeout drained=%b exp=1", done); end
        vectors++; if (n != MAXC) begin miscompares++; $display("FAIL sat_drain_count got=%0d exp=%0d", n, MAXC); end
    endtask

    task automatic test_illegal();
        force_en = 1'b1; force_grant = '0; ready = 1'b0;
        force_grant = 4'b1000; tick(); force_grant = '0;
        vectors++; if (err !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL ill_idle_grant err=%b valid=%b, expected 1/0", err, valid); end
        tick();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ill_idle_pulse got=%b exp=0", err); end
        push = 4'b0110; tick(); push = '0; tick();
        vectors++; if (request !== 4'b0110 || err !== 1'b0) begin miscompares++; $display("FAIL ill_req req=%b err=%b, expected 0110/0", request, err); end
        force_grant = 4'b0110; tick(); force_grant = '0;
        vectors++; if (err !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL ill_multihot err=%b valid=%b, expected 1/0", err, valid); end
        tick();
        vectors++; if (err !== 1'b0 || valid !== 1'b0 || request !== 4'b0110) begin miscompares++; $display("FAIL ill_multihot_after err=%b valid=%b req=%b, expected 0/0/0110", err, valid, request); end
        force_grant = 4'b0001; tick(); force_grant = '0;
        vectors++; if (err !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL ill_zero_cnt err=%b valid=%b, expected 1/0", err, valid); end
        tick();
        vectors++; if (err !== 1'b0 || request !== 4'b0110) begin miscompares++; $display("FAIL ill_zero_cnt_after err=%b req=%b, expected 0/0110", err, request); end
        force_grant = 4'b0100; tick(); force_grant = 4'b1111;
        vectors++; if (valid !== 1'b1 || id !== 2'd2 || request !== '0 || err !== 1'b0) begin miscompares++; $display("FAIL ill_legal valid=%b id=%0d req=%b err=%b, expected 1/2/0000/0", valid, id, request, err); end
        tick();
        vectors++; if (err !== 1'b0 || valid !== 1'b1) begin miscompares++; $display("FAIL ill_grant_in_issue err=%b valid=%b, expected 0/1", err, valid); end
        force_grant = '0; rst_n = 1'b0; tick(); rst_n = 1'b1;
        vectors++; if (valid !== 1'b0 || request !== '0 || pending_any !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL ill_reset_issue valid=%b req=%b pend=%b err=%b, expected all 0", valid, request, pending_any, err); end
        tick();
        vectors++; if (valid !== 1'b0 || pending_any !== 1'b0) begin miscompares++; $display("FAIL ill_reset_after valid=%b pend=%b, expected 0/0", valid, pending_any); end
        force_en = 1'b0;
    endtask

    task automatic test_random();
        int              cm [N];
        logic [N-1:0]    pv;
        logic [N-1:0]    mask;
        logic            rd;
        logic            q;
        logic            exp_ovf;
        logic            prev_valid;
        logic            prev_ready;
        logic [ID_W-1:0] prev_id;
        logic [N-1:0]    prev_grant;
        for (int i = 0; i < N; i++) cm[i] = 0;
        for (int c = 0; c < 800; c++) begin
            if (c < 400) begin
                for (int i = 0; i < N; i++) pv[i] = ($urandom_range(0, 7) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end else begin
                pv = '0;
                rd = 1'b1;
            end
            push = pv; ready = rd;
            exp_ovf = 1'b0;
            for (int i = 0; i < N; i++) begin
                q = valid && rd && (id == ID_W'(i));
                if (q) begin
                    vectors++; if (cm[i] == 0) begin miscompares++; $display("FAIL rnd_pop_empty cycle %0d client %0d had 0 pending, expected >0", c, i); end
                end
                if (pv[i] && !q) begin
                    if (cm[i] == MAXC) exp_ovf = 1'b1;
                    else cm[i]++;
                end else if (q && !pv[i] && cm[i] > 0) begin
                    cm[i]--;
                end
            end
            prev_valid = valid; prev_ready = rd; prev_id = id; prev_grant = grant;
            tick();
            for (int i = 0; i < N; i++) mask[i] = (cm[i] > 0);
            vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL rnd_ovf cycle %0d got=%b exp=%b", c, overflow, exp_ovf); end
            vectors++; if (pending_any !== (|mask)) begin miscompares++; $display("FAIL rnd_pending cycle %0d got=%b exp=%b", c, pending_any, |mask); end
            vectors++; if (request !== (valid ? '0 : mask)) begin miscompares++; $display("FAIL rnd_request cycle %0d got=%b exp=%b (valid=%b)", c, request, (valid ? '0 : mask), valid); end
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rnd_err cycle %0d got=%b exp=0", c, err); end
            if (prev_valid) begin
                vectors++; if (valid !== !prev_ready || (!prev_ready && id !== prev_id)) begin miscompares++; $display("FAIL rnd_handshake cycle %0d valid=%b id=%0d, expected valid=%b id=%0d", c, valid, id, !prev_ready, prev_id); end
            end else if (valid) begin
                vectors++; if (prev_grant !== (N'(1) << id)) begin miscompares++; $display("FAIL rnd_issue_id cycle %0d id=%0d but granted %b", c, id, prev_grant); end
            end
        end
        for (int i = 0; i < N; i++) mask[i] = (cm[i] > 0);
        vectors++; if (mask !== '0 || pending_any !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL rnd_drain model=%b pend=%b valid=%b, expected 0000/0/0", mask, pending_any, valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_saturation();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
